// File: rtl/noc_pkt_pkg.sv
// NoC packet layout shared by the ifmap memory and all PE-side endpoints.
package noc_pkt_pkg;

  localparam int PKT_W  = 32;
  localparam int DT_W   = 2;
  localparam int ADDR_W = 8;
  localparam int COL_W  = 8;
  localparam int DATA_W = 13;

  typedef enum logic [DT_W-1:0] {
    DT_NONE  = 2'b00,
    DT_IFMAP = 2'b01,
    DT_FILT  = 2'b10,
    DT_PSUM  = 2'b11
  } data_type_e;

  typedef struct packed {
    logic              rsvd;
    data_type_e        dtype;
    logic [ADDR_W-1:0] dst_addr;
    logic [COL_W-1:0]  col;
    logic [DATA_W-1:0] data;
  } pkt_t;

endpackage

// File: rtl/ifmap_row_bank.sv
// One row buffer: element storage, per-column fill bitmap and fill count.
// Completion is decided by the parent; clr wipes bitmap/count only.
module ifmap_row_bank #(
  parameter int WIDTH_DATA = 13,
  parameter int WIDTH_I    = 25,
  parameter int AW         = 5,
  parameter int CW         = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_col,
  input  logic [WIDTH_DATA-1:0] wr_data,
  input  logic                  clr,
  input  logic [AW-1:0]         rd_addr,
  output logic [WIDTH_DATA-1:0] rd_data,
  output logic                  hit,
  output logic [CW-1:0]         cnt
);

  logic [WIDTH_DATA-1:0] mem_q [WIDTH_I];
  logic [WIDTH_I-1:0]    bmap_q;
  logic [CW-1:0]         cnt_q;

  assign hit     = bmap_q[wr_col];
  assign cnt     = cnt_q;
  assign rd_data = mem_q[rd_addr];

  // Data store: duplicates simply overwrite, no reset needed (gated by bitmap/full).
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_col] <= wr_data;
  end

  // Fill tracking: only first write of a column counts; clr wins on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bmap_q <= '0;
      cnt_q  <= '0;
    end else if (clr) begin
      bmap_q <= '0;
      cnt_q  <= '0;
    end else if (wr_en && !hit) begin
      bmap_q[wr_col] <= 1'b1;
      cnt_q          <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/ifmap_row_rx.sv
// PE-side ifmap receiver: filters NoC packets, assembles rows into two
// ping-pong banks and serves completed rows through a registered read port.
// Optional IFMAP_RX_STATS_EN adds saturating accept/drop counters.
module ifmap_row_rx
  import noc_pkt_pkg::*;
#(
  parameter int          WIDTH_DATA = 13,
  parameter int          WIDTH_I    = 25,
  parameter int          DEPTH_I    = 25,
  parameter logic [7:0]  PE_ADDR    = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           in_pkt,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  row_valid,
  input  logic [4:0]            rd_addr,
  input  logic                  rd_en,
  output logic [WIDTH_DATA-1:0] rd_data,
  input  logic                  row_release,
  output logic [4:0]            row_idx,
  output logic                  frame_done,
  output logic                  err_drop
`ifdef IFMAP_RX_STATS_EN
  ,output logic [15:0]          stat_acc
  ,output logic [15:0]          stat_drop
`endif
);

  localparam int             AW       = $clog2(WIDTH_I);
  localparam int             CW       = $clog2(WIDTH_I + 1);
  localparam logic [7:0]     COL_LIM  = 8'(WIDTH_I);
  localparam logic [4:0]     RD_LIM   = 5'(WIDTH_I);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH_I - 1);
  localparam logic [4:0]     ROW_LAST = 5'(DEPTH_I - 1);

  pkt_t pkt;
  logic acc, pkt_ok, wr_ok, row_done, rel;

  logic [1:0]                 full_q, full_d;
  logic                       wr_bank_q, wr_bank_d;
  logic                       rd_bank_q, rd_bank_d;
  logic [4:0]                 row_idx_q, row_idx_d;
  logic [WIDTH_DATA-1:0]      rd_data_q, rd_data_d;
  logic                       frame_done_q, frame_done_d;
  logic                       err_drop_q, err_drop_d;

  logic [1:0]                 bank_wr, bank_clr, bank_hit;
  logic [1:0][WIDTH_DATA-1:0] bank_rd;
  logic [1:0][CW-1:0]         bank_cnt;

  assign pkt       = pkt_t'(in_pkt);
  assign in_ready  = !full_q[wr_bank_q];
  assign row_valid = full_q[rd_bank_q];
  assign acc       = in_valid && in_ready;
  // rsvd intentionally not examined
  assign pkt_ok    = (pkt.dtype == DT_IFMAP) && (pkt.dst_addr == PE_ADDR) &&
                     (pkt.col < COL_LIM);
  assign wr_ok     = acc && pkt_ok;
  // Row closes on the write that adds the last missing column.
  assign row_done  = wr_ok && !bank_hit[wr_bank_q] && (bank_cnt[wr_bank_q] == CNT_LAST);
  assign rel       = row_release && row_valid;

  // Steer write/clear strobes to the current write bank.
  always_comb begin
    bank_wr             = '0;
    bank_clr            = '0;
    bank_wr[wr_bank_q]  = wr_ok;
    bank_clr[wr_bank_q] = row_done;
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    ifmap_row_bank #(
      .WIDTH_DATA (WIDTH_DATA),
      .WIDTH_I    (WIDTH_I),
      .AW         (AW),
      .CW         (CW)
    ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (bank_wr[b]),
      .wr_col  (pkt.col[AW-1:0]),
      .wr_data (pkt.data[WIDTH_DATA-1:0]),
      .clr     (bank_clr[b]),
      .rd_addr (rd_addr[AW-1:0]),
      .rd_data (bank_rd[b]),
      .hit     (bank_hit[b]),
      .cnt     (bank_cnt[b])
    );
  end

  // Next state: release and completion always target different banks
  // (release needs full, completion needs not-full), so both apply.
  always_comb begin
    full_d       = full_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    row_idx_d    = row_idx_q;
    frame_done_d = 1'b0;
    err_drop_d   = acc && !pkt_ok;
    rd_data_d    = rd_data_q;
    if (rel) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
      if (row_idx_q == ROW_LAST) begin
        row_idx_d    = '0;
        frame_done_d = 1'b1;
      end else begin
        row_idx_d = row_idx_q + 1'b1;
      end
    end
    if (row_done) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end
    if (rd_en && row_valid && (rd_addr < RD_LIM)) rd_data_d = bank_rd[rd_bank_q];
  end

  // Control/state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q       <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      row_idx_q    <= '0;
      rd_data_q    <= '0;
      frame_done_q <= 1'b0;
      err_drop_q   <= 1'b0;
    end else begin
      full_q       <= full_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      row_idx_q    <= row_idx_d;
      rd_data_q    <= rd_data_d;
      frame_done_q <= frame_done_d;
      err_drop_q   <= err_drop_d;
    end
  end

  assign rd_data    = rd_data_q;
  assign row_idx    = row_idx_q;
  assign frame_done = frame_done_q;
  assign err_drop   = err_drop_q;

`ifdef IFMAP_RX_STATS_EN
  logic [15:0] stat_acc_q, stat_drop_q;

  // Saturating counters, zeroed on the edge that wraps the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_acc_q  <= '0;
      stat_drop_q <= '0;
    end else if (frame_done_d) begin
      stat_acc_q  <= '0;
      stat_drop_q <= '0;
    end else begin
      if (wr_ok && (stat_acc_q != 16'hFFFF))       stat_acc_q  <= stat_acc_q + 1'b1;
      if (err_drop_d && (stat_drop_q != 16'hFFFF)) stat_drop_q <= stat_drop_q + 1'b1;
    end
  end

  assign stat_acc  = stat_acc_q;
  assign stat_drop = stat_drop_q;
`endif

endmodule

// File: tb/tb_ifmap_row_rx.sv
// Directed bench for ifmap_row_rx: table-driven filter/row vectors and read
// checks, plus hand sequences for back-pressure, reset and frame wrap.
module tb_ifmap_row_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_pkt = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, row_valid;
  logic [4:0]  rd_addr = '0;
  logic        rd_en = 1'b0;
  logic [12:0] rd_data;
  logic        row_release = 1'b0;
  logic [4:0]  row_idx;
  logic        frame_done, err_drop;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ifmap_row_rx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_pkt      (in_pkt),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .row_valid   (row_valid),
    .rd_addr     (rd_addr),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .row_release (row_release),
    .row_idx     (row_idx),
    .frame_done  (frame_done),
    .err_drop    (err_drop)
  );

  typedef struct {
    logic [31:0] pkt;
    logic        exp_drop;
    logic        exp_rowv;
  } vec_t;

  typedef struct {
    logic [4:0]  addr;
    logic [12:0] exp;
  } rdv_t;

  function automatic logic [31:0] mk(input logic rs, input logic [1:0] dt,
                                     input logic [7:0] dst, input logic [7:0] col,
                                     input logic [12:0] d);
    return {rs, dt, dst, col, d};
  endfunction

  function automatic logic [31:0] good(input int col, input int d);
    return mk(1'b0, 2'b01, 8'h00, 8'(col), 13'(d));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present a packet, wait (bounded) for in_ready, transfer on one edge.
  task automatic send(input logic [31:0] p);
    int n;
    n = 0;
    in_pkt   = p;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic rd(input string name, input int a, input int exp);
    rd_addr = 5'(a);
    rd_en   = 1'b1;
    @(posedge clk); #1;
    rd_en   = 1'b0;
    chk(name, 32'(rd_data), 32'(exp));
  endtask

  task automatic release_row();
    row_release = 1'b1;
    @(posedge clk); #1;
    row_release = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t v[$];
    rdv_t rv[$];
    int   fd_cnt;

    // Filtering + in-order row vectors.
    v.push_back('{good(0, 100), 1'b0, 1'b0});
    v.push_back('{mk(1'b0, 2'b10, 8'h00, 8'd1, 13'd1), 1'b1, 1'b0});
    v.push_back('{mk(1'b0, 2'b01, 8'h01, 8'd1, 13'd1), 1'b1, 1'b0});
    v.push_back('{mk(1'b0, 2'b01, 8'h00, 8'd30, 13'd1), 1'b1, 1'b0});
    v.push_back('{mk(1'b0, 2'b00, 8'h00, 8'd1, 13'd1), 1'b1, 1'b0});
    v.push_back('{mk(1'b1, 2'b01, 8'h00, 8'd1, 13'd101), 1'b0, 1'b0});
    for (int c = 2; c < 25; c++) v.push_back('{good(c, c + 100), 1'b0, (c == 24)});

    rv.push_back('{5'd7, 13'd107});
    rv.push_back('{5'd0, 13'd100});
    rv.push_back('{5'd24, 13'd124});
    rv.push_back('{5'd25, 13'd124});

    // Reset state.
    #12;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_row_valid", 32'(row_valid), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_row_idx", 32'(row_idx), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_err_drop", 32'(err_drop), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Filtering and in-order row.
    foreach (v[i]) begin
      send(v[i].pkt);
      chk($sformatf("vec%0d_err_drop", i), 32'(err_drop), 32'(v[i].exp_drop));
      chk($sformatf("vec%0d_row_valid", i), 32'(row_valid), 32'(v[i].exp_rowv));
    end
    foreach (rv[i]) rd($sformatf("rd%0d_addr%0d", i, rv[i].addr), int'(rv[i].addr), int'(rv[i].exp));
    chk("row0_idx", 32'(row_idx), 0);
    chk("row0_in_ready", 32'(in_ready), 1);
    release_row();
    chk("rel1_row_valid", 32'(row_valid), 0);
    chk("rel1_row_idx", 32'(row_idx), 1);
    chk("rel1_frame_done", 32'(frame_done), 0);
    rd("rd_no_valid_hold", 3, 124);

    // Out-of-order with a duplicate before the last column.
    for (int c = 24; c >= 1; c--) send(good(c, c + 200));
    send(good(5, 999));
    chk("dup_not_complete", 32'(row_valid), 0);
    send(good(0, 200));
    chk("dup_complete", 32'(row_valid), 1);
    rd("dup_col5", 5, 999);
    rd("dup_col24", 24, 224);
    rd("dup_col0", 0, 200);
    release_row();
    chk("rel2_row_idx", 32'(row_idx), 2);

    // Back-pressure: two full rows, a held 51st packet.
    for (int c = 0; c < 25; c++) send(good(c, c + 300));
    chk("bp_rowA_valid", 32'(row_valid), 1);
    chk("bp_rowA_ready", 32'(in_ready), 1);
    for (int c = 0; c < 25; c++) send(good(c, c + 400));
    chk("bp_both_full_ready", 32'(in_ready), 0);
    in_pkt   = good(0, 777);
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_held_ready", 32'(in_ready), 0);
    row_release = 1'b1;
    #2;
    chk("bp_ready_not_comb", 32'(in_ready), 0);
    @(posedge clk); #1;
    row_release = 1'b0;
    chk("bp_ready_after_rel", 32'(in_ready), 1);
    chk("bp_rowB_valid", 32'(row_valid), 1);
    chk("bp_row_idx3", 32'(row_idx), 3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rd("bp_rowB_col3", 3, 403);
    release_row();
    chk("bp_row_idx4", 32'(row_idx), 4);
    chk("bp_empty", 32'(row_valid), 0);
    for (int c = 1; c < 25; c++) begin
      send(good(c, c + 500));
      if (c == 23) chk("bp_held_not_double", 32'(row_valid), 0);
    end
    chk("bp_held_row_valid", 32'(row_valid), 1);
    rd("bp_held_col0", 0, 777);
    rd("bp_held_col1", 1, 501);
    release_row();
    chk("bp_row_idx5", 32'(row_idx), 5);

    // Reset with one full row and a partial row buffered.
    for (int c = 0; c < 25; c++) send(good(c, c + 600));
    for (int c = 0; c < 10; c++) send(good(c, c + 700));
    rd("pre_rst_rd", 2, 602);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    chk("mid_rst_row_valid", 32'(row_valid), 0);
    chk("mid_rst_rd_data", 32'(rd_data), 0);
    chk("mid_rst_row_idx", 32'(row_idx), 0);
    chk("mid_rst_frame_done", 32'(frame_done), 0);
    chk("mid_rst_err_drop", 32'(err_drop), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full frame: 25 rows, each released.
    fd_cnt = 0;
    for (int r = 0; r < 25; r++) begin
      for (int c = 0; c < 25; c++) begin
        send(good(c, r * 32 + c));
        if (c == 23) chk($sformatf("fr%0d_partial", r), 32'(row_valid), 0);
      end
      chk($sformatf("fr%0d_valid", r), 32'(row_valid), 1);
      chk($sformatf("fr%0d_idx", r), 32'(row_idx), 32'(r));
      rd($sformatf("fr%0d_rd", r), r, r * 32 + r);
      release_row();
      chk($sformatf("fr%0d_frame_done", r), 32'(frame_done), 32'(r == 24));
      if (frame_done) fd_cnt++;
    end
    chk("fr_wrap_idx", 32'(row_idx), 0);
    @(posedge clk); #1;
    chk("fr_done_one_cycle", 32'(frame_done), 0);
    chk("fr_done_count", 32'(fd_cnt), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifmap_row_rx.md
Name: ifmap_row_rx

Overview:
- PE-side receiver directly downstream of the ifmap memory's packet output.
- Accepts 32-bit NoC packets, keeps only ifmap packets addressed to this PE, and assembles them into complete ifmap rows in a double-buffered row store.
- Presents each completed row to the PE datapath through a synchronous read port; the PE releases the row when it is done with it.
- Clocked block; one clock, asynchronous active-low reset.

Parameters:
- WIDTH_DATA, 13, ifmap element width (packet bits [12:0]).
- WIDTH_I, 25, elements per row; legal column indices 0..WIDTH_I-1.
- DEPTH_I, 25, rows per frame.
- PE_ADDR, 8'h00, this PE's NoC address, compared with packet dst_addr.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_pkt, input, 32, packet {rsvd[31], data_type[30:29], dst_addr[28:21], col[20:13], data[12:0]}.
- in_valid, input, 1, in_pkt is valid.
- in_ready, output, 1, receiver can accept in_pkt this cycle.
- row_valid, output, 1, a complete row is readable.
- rd_addr, input, 5, column to read (0..WIDTH_I-1).
- rd_en, input, 1, read strobe.
- rd_data, output, WIDTH_DATA, registered read data.
- row_release, input, 1, PE is done with the current row (one-cycle pulse).
- row_idx, output, 5, index within the frame of the row presented on the read side.
- frame_done, output, 1, one-cycle pulse when row DEPTH_I-1 is released.
- err_drop, output, 1, one-cycle pulse when an accepted packet is discarded.

Behaviour:
- Reset (async, rst_n=0): both banks empty, all bitmaps and counts cleared.
  - wr_bank=0, rd_bank=0, row_idx=0.
  - in_ready=1, row_valid=0, rd_data=0, frame_done=0, err_drop=0.
- Handshake: a packet transfers on a rising clk when in_valid && in_ready. in_ready = !full[wr_bank], combinational from state only and never from in_valid.
- Packet checks, in priority order:
  - data_type != 2'b01, dst_addr != PE_ADDR, or col >= WIDTH_I: the packet is consumed and discarded, err_drop pulses the next cycle, and no state changes.
  - rsvd is ignored.
- Write path for a valid packet: bank[wr_bank][col] <= data.
  - If bitmap[col] was clear: set it and increment count.
  - If bitmap[col] was already set (duplicate): overwrite the data, leave count unchanged, no error.
- Row completion: when count reaches WIDTH_I on a write, on the same edge set full[wr_bank], clear that bank's bitmap and count, and toggle wr_bank.
- Read side:
  - row_valid = full[rd_bank].
  - rd_en with row_valid gives rd_data = bank[rd_bank][rd_addr] one cycle later.
  - rd_en without row_valid, or rd_addr >= WIDTH_I, holds rd_data unchanged.
- Release: row_release with row_valid clears full[rd_bank] and toggles rd_bank. row_idx then increments, wrapping DEPTH_I-1 -> 0; frame_done pulses on the wrap. row_release without row_valid is ignored.
- Simultaneous events:
  - A release of bank X and a row completion into bank Y on the same edge are both honoured.
  - When both banks are full, in_ready=0. A release re-asserts in_ready on the next cycle, never combinationally.
- Back-pressure only stalls ingress. Packets are never lost while in_ready=0.
- Reset mid-row discards partial and full rows without any pulses.

Optional Feature:
- IFMAP_RX_STATS_EN defined: adds outputs stat_acc[15:0] and stat_drop[15:0].
  - Saturating counts of written and discarded packets.
  - Reset to 0 and cleared when frame_done pulses.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package noc_pkt_pkg:
  - pkt_t packed struct matching the field layout above.
  - DT_IFMAP=2'b01 and the other data_type codes.
  - Field width constants.
  - Shared with the ifmap memory and the other NoC endpoints.
- One sub-module, ifmap_row_bank:
  - Single bank storage, bitmap, and count.
  - Write/clear/read ports, with full detection done in the parent.
  - Instantiated twice.

Test Plan:
- In-order row: send 25 packets (dst=PE_ADDR, type 01, col 0..24, data=col+100). Expect row_valid 1 cycle after the last write; rd_addr=7 returns 107; row_idx=0.
- Filtering: send type 10, dst=PE_ADDR+1, and col=30. Expect err_drop to pulse three times with count unchanged, then complete the row normally.
- Duplicate/out-of-order: send cols 24..0, then col 5 again with data 999 before the final col. Expect completion after 25 distinct cols and readback 999 at col 5.
- Back-pressure: fill two rows without release. Expect in_ready=0 and a 51st packet held. Pulse row_release: expect in_ready=1 next cycle and the held packet written to col 0.
- Frame wrap: stream 25 rows, releasing each. Expect row_idx to step 0..24, frame_done once on the last release, and row_idx=0 afterwards.
- Reset mid-row: assert rst_n=0 after 10 writes. Expect all outputs at reset values. A fresh 25-packet row completes normally.
